// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
`default_nettype none

package ifu_pkg;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          INST_W   = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        HALT = 3'd4
    } ifu_state_t;

    // Instructions are 32-bit aligned; any set low bit is a fetch fault.
    function automatic logic pc_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_pc.sv
// ifu_pc: program counter register with redirect mux and +4 incrementer.
`default_nettype none

module ifu_pc #(
    parameter int                XLEN     = ifu_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(ifu_pkg::RESET_PC)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misaligned_o
);
    import ifu_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect wins over sequential advance; the add wraps modulo 2^XLEN.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o         = pc_q;
    assign misaligned_o = pc_misaligned(pc_q[1:0]);

endmodule

`default_nettype wire

// File: rtl/ifu.sv
// ifu: single-outstanding instruction fetch with redirect/squash, feeding decode
// over a valid/ready handshake.
`default_nettype none

module ifu #(
    parameter int              XLEN     = ifu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(ifu_pkg::RESET_PC)
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [ifu_pkg::INST_W-1:0] imem_rsp_data,
    input  logic                       imem_rsp_err,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [ifu_pkg::INST_W-1:0] instruction,
    output logic [XLEN-1:0]            inst_pc,
    output logic                       inst_fault,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc
);
    import ifu_pkg::*;

    ifu_state_t          state_q;
    logic                kill_q;
    logic [INST_W-1:0]   instruction_q;
    logic [XLEN-1:0]     inst_pc_q;
    logic                fault_q;

    logic [XLEN-1:0]     pc;
    logic                misaligned;
    logic                redirect_take;
    logic                advance;
    logic                req_fire;

    // Redirects are not honoured while coming out of reset.
    assign redirect_take = redirect_valid && (state_q != IDLE);
    assign advance       = (state_q == OUT) && inst_ready && !fault_q && !redirect_valid;

    assign imem_req_valid = (state_q == REQ) && !misaligned;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_valid  = (state_q == OUT) && !redirect_valid;
    assign instruction = instruction_q;
    assign inst_pc     = inst_pc_q;
    assign inst_fault  = fault_q;

    ifu_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i         (clk),
        .rst_ni        (rst),
        .redirect_i    (redirect_take),
        .redirect_pc_i (redirect_pc),
        .advance_i     (advance),
        .pc_o          (pc),
        .misaligned_o  (misaligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            kill_q        <= 1'b0;
            instruction_q <= '0;
            inst_pc_q     <= '0;
            fault_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (redirect_valid) begin
                        // An accepted request whose address is now stale must be drained.
                        if (req_fire) begin
                            state_q <= WAIT;
                            kill_q  <= 1'b1;
                        end
                    end else if (misaligned) begin
                        instruction_q <= '0;
                        fault_q       <= 1'b1;
                        inst_pc_q     <= pc;
                        state_q       <= OUT;
                    end else if (req_fire) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        if (imem_rsp_valid) begin
                            kill_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            kill_q  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= REQ;
                        end else begin
                            instruction_q <= imem_rsp_data;
                            fault_q       <= imem_rsp_err;
                            inst_pc_q     <= pc;
                            state_q       <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (redirect_valid) begin
                        state_q <= REQ;
                    end else if (inst_ready) begin
                        state_q <= fault_q ? HALT : REQ;
                    end
                end
                HALT: begin
                    if (redirect_valid) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// tb_ifu: directed checks of fetch sequencing, stalls, redirects, faults and reset.
`default_nettype none

module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        imem_rsp_err   = 1'b0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int          n_checks = 0;
    int          n_pass   = 0;

    // Memory responder configuration.
    int          rsp_delay = 0;
    logic [31:0] rsp_word  = 32'h0000_0013;
    logic [63:0] err_addr  = 64'h1;
    logic        pend      = 1'b0;
    int          cnt       = 0;
    logic [63:0] pend_addr = 64'h0;
    logic        hs_s;
    logic [63:0] hs_addr;

    always #5 clk = ~clk;

    ifu u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // One outstanding request; response rsp_delay cycles after the zero-wait slot.
    always @(posedge clk) begin
        hs_s    = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (hs_s) begin
            pend      = 1'b1;
            cnt       = rsp_delay;
            pend_addr = hs_addr;
        end
        if (pend) begin
            if (cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = rsp_word;
                imem_rsp_err   = (pend_addr == err_addr);
                pend           = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 64'd0);
        check({tag, "_req_addr"},  imem_req_addr,  64'h8000_0000);
        check({tag, "_inst_valid"}, inst_valid,    64'd0);
        check({tag, "_instr"},     instruction,    64'd0);
        check({tag, "_inst_pc"},   inst_pc,        64'd0);
        check({tag, "_fault"},     inst_fault,     64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        #3 rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst = 1'b1;
        tick();
        check("first_req_valid", imem_req_valid, 64'd1);
        check("first_req_addr",  imem_req_addr,  64'h8000_0000);

        // Zero-wait streaming: one instruction every third cycle.
        for (int i = 0; i < 9; i++) begin
            check("stream_valid", inst_valid, (i % 3 == 2) ? 64'd1 : 64'd0);
            if (i % 3 == 2) begin
                check("stream_pc",    inst_pc,     64'h8000_0000 + 64'(4 * (i / 3)));
                check("stream_instr", instruction, 64'h13);
            end
            tick();
        end

        // Decode back-pressure for five cycles in OUT.
        check("stall_req_addr", imem_req_addr, 64'h8000_000C);
        inst_ready = 1'b0;
        rsp_word   = 32'h0000_0093;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall_valid",     inst_valid,     64'd1);
            check("stall_pc",        inst_pc,        64'h8000_000C);
            check("stall_instr",     instruction,    64'h93);
            check("stall_req_valid", imem_req_valid, 64'd0);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        check("resume_req_valid", imem_req_valid, 64'd1);
        check("resume_req_addr",  imem_req_addr,  64'h8000_0010);

        // Redirect while waiting on a slow response.
        rsp_delay = 3;
        rsp_word  = 32'hDEAD_BEEF;
        tick();
        check("wait_req_valid", imem_req_valid, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("kill_req_valid0", imem_req_valid, 64'd0);
        tick();
        check("kill_req_valid1", imem_req_valid, 64'd0);
        tick();
        check("kill_rsp_valid", inst_valid, 64'd0);
        check("kill_req_valid2", imem_req_valid, 64'd0);
        tick();
        check("redir_req_valid", imem_req_valid, 64'd1);
        check("redir_req_addr",  imem_req_addr,  64'h8000_0100);
        check("redir_instr_kept", instruction,   64'h93);
        rsp_delay = 0;
        rsp_word  = 32'h0000_0013;
        tick();
        tick();
        check("redir_out_valid", inst_valid,  64'd1);
        check("redir_out_pc",    inst_pc,     64'h8000_0100);
        check("redir_out_instr", instruction, 64'h13);
        tick();

        // Redirect to a misaligned PC during a request handshake.
        check("pre_mis_addr", imem_req_addr, 64'h8000_0104);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        check("mis_drain_req_valid", imem_req_valid, 64'd0);
        tick();
        check("mis_no_req",     imem_req_valid, 64'd0);
        check("mis_req_addr",   imem_req_addr,  64'h8000_0102);
        check("mis_inst_valid", inst_valid,     64'd0);
        tick();
        check("mis_out_valid", inst_valid,  64'd1);
        check("mis_out_fault", inst_fault,  64'd1);
        check("mis_out_pc",    inst_pc,     64'h8000_0102);
        check("mis_out_instr", instruction, 64'd0);
        tick();
        check("halt_inst_valid0", inst_valid,     64'd0);
        check("halt_req_valid0",  imem_req_valid, 64'd0);
        tick();
        check("halt_inst_valid1", inst_valid,     64'd0);
        check("halt_req_valid1",  imem_req_valid, 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        check("halt_exit_req_valid", imem_req_valid, 64'd1);
        check("halt_exit_req_addr",  imem_req_addr,  64'h8000_0200);
        err_addr = 64'h8000_0008;

        // Redirect coinciding with a response, then an access fault.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        check("err_req_valid",  imem_req_valid, 64'd1);
        check("err_req_addr",   imem_req_addr,  64'h8000_0008);
        check("err_inst_valid", inst_valid,     64'd0);
        tick();
        tick();
        check("err_out_valid", inst_valid, 64'd1);
        check("err_out_fault", inst_fault, 64'd1);
        check("err_out_pc",    inst_pc,    64'h8000_0008);
        tick();
        check("err_halt_valid",     inst_valid,     64'd0);
        check("err_halt_req_valid", imem_req_valid, 64'd0);
        err_addr       = 64'h1;
        rsp_delay      = 2;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;

        // Asynchronous reset while a fetch is outstanding.
        tick();
        redirect_valid = 1'b0;
        check("pre_rst_req_valid", imem_req_valid, 64'd1);
        check("pre_rst_req_addr",  imem_req_addr,  64'h8000_0300);
        tick();
        check("pre_rst_wait", imem_req_valid, 64'd0);
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst       = 1'b1;
        rsp_delay = 0;
        tick();
        check("post_rst_req_valid", imem_req_valid, 64'd1);
        check("post_rst_req_addr",  imem_req_addr,  64'h8000_0000);
        check("post_rst_inst_valid", inst_valid,    64'd0);
        tick();
        tick();
        check("post_rst_out_valid", inst_valid,  64'd1);
        check("post_rst_out_pc",    inst_pc,     64'h8000_0000);
        check("post_rst_out_instr", instruction, 64'h13);
        check("post_rst_out_fault", inst_fault,  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit: holds the PC, issues one 32-bit instruction read at a time to instruction memory over a valid/ready request and valid response channel, and presents the fetched word with its PC to `decode` over a valid/ready handshake. It sits directly upstream of `decode`, and `instruction` drives decode's `instruction` input. It accepts PC redirects from the branch/jump resolution stage and squashes any in-flight fetch. Fetch is multicycle: one outstanding request, no prefetch.

## Interface
- `XLEN`, 64, PC and address width
- `RESET_PC`, 64'h8000_0000, first fetch address after reset
- `clk` input 1, rising-edge clock
- `rst` input 1, reset; asynchronous assert, active-low (0 = reset)
- `imem_req_valid` output 1, request pending
- `imem_req_ready` input 1, memory accepts request
- `imem_req_addr` output XLEN, fetch address; equals the current PC
- `imem_rsp_valid` input 1, response data valid for one cycle
- `imem_rsp_data` input 32, fetched instruction word
- `imem_rsp_err` input 1, access fault on this response
- `inst_valid` output 1, instruction available to decode
- `inst_ready` input 1, decode accepts
- `instruction` output 32, instruction word to decode
- `inst_pc` output XLEN, PC of `instruction`
- `inst_fault` output 1, fetch fault (misaligned PC or `imem_rsp_err`)
- `redirect_valid` input 1, redirect request
- `redirect_pc` input XLEN, redirect target

## Operation
- States: IDLE, REQ, WAIT, OUT, HALT.
- IDLE is reset-only and transitions unconditionally to REQ.
- REQ:
  - `imem_req_valid`=1.
  - If `pc[1:0]`!=0, no request is issued. Instead: `instruction`=0, `inst_fault`=1, `inst_pc`=pc, go to OUT.
  - On `imem_req_ready`, go to WAIT.
- WAIT: waits for `imem_rsp_valid`. On response, latch `imem_rsp_data`, `imem_rsp_err`→`inst_fault`, and `inst_pc`=pc, then go to OUT.
- OUT:
  - `inst_valid`=1.
  - On `inst_ready`: if no fault, pc←pc+4 and go to REQ; if fault, go to HALT.
- HALT: all valids 0; only a redirect leaves this state.
- Redirect (`redirect_valid`=1) takes priority over every other event in any non-IDLE state:
  - pc←`redirect_pc`.
  - REQ with no handshake this cycle: stay in REQ with the new address next cycle.
  - REQ with handshake this cycle: go to WAIT with `kill`=1.
  - WAIT, no response this cycle: set `kill`=1, stay in WAIT.
  - WAIT with response this cycle: discard the response, go to REQ.
  - OUT: the latched instruction is dropped; go to REQ.
  - HALT: go to REQ.
- In WAIT with `kill`=1, a response is discarded, `kill` clears, and the state goes to REQ at the current pc.
- `inst_valid` = (state==OUT) && !`redirect_valid`, so no decode handshake can occur in a redirect cycle.
- `imem_req_valid` is likewise masked by `redirect_valid` only when the state is not REQ; it is never masked in REQ.
- PC arithmetic is modulo 2^XLEN; pc+4 wraps without a flag.
- `imem_rsp_valid` outside WAIT is ignored.

## Timing
- Reset values:
  - state=IDLE, pc=`RESET_PC`, `kill`=0.
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `instruction`=0, `inst_pc`=0, `inst_fault`=0.
- First `imem_req_valid` is asserted 1 cycle after `rst` deasserts.
- Best-case throughput, with zero-wait memory (response in the cycle after the request) and `inst_ready` tied 1: 1 instruction per 3 cycles (REQ, WAIT, OUT).
- `instruction`, `inst_pc`, `inst_fault` are registered and stable throughout OUT.
- Redirect latency: the new PC appears on `imem_req_addr` in the cycle after `redirect_valid`, unless a killed fetch is outstanding, in which case it waits for that response plus 1 cycle.
- Asserting `rst` mid-fetch forces IDLE immediately. A memory response still in flight after reset must be absorbed by the memory side; `ifu` ignores it because it is not in WAIT.

## Structure
- Package `ifu_pkg` holds:
  - the state enum `ifu_state_t`
  - `XLEN`
  - `RESET_PC` default
  - `INST_W`=32
- Sub-module `ifu_pc`: PC register with async active-low reset, redirect mux, and +4 incrementer. It outputs pc and the misaligned flag.

## Test plan
- Reset release, zero-wait memory returning 32'h00000013 at each address, `inst_ready`=1: `inst_pc` sequence is 8000_0000, 8000_0004, 8000_0008, with `inst_valid` asserted every 3rd cycle.
- `inst_ready`=0 for 5 cycles in OUT: `instruction`/`inst_pc` are held and no new `imem_req_valid` is issued; one cycle after `inst_ready` rises, `imem_req_addr`=pc+4.
- `redirect_valid` with `redirect_pc`=8000_0100 while in WAIT: the late response 32'hDEADBEEF never appears on `instruction`; the next request address is 8000_0100.
- `redirect_pc`=8000_0102: no memory request is issued; `inst_valid`=1 with `inst_fault`=1 and `inst_pc`=8000_0102; after the handshake, HALT until a redirect to 8000_0200 resumes fetch.
- `imem_rsp_err`=1 at 8000_0008: `inst_fault`=1 with `inst_pc`=8000_0008, then HALT.
- `rst` asserted during WAIT: outputs return to reset values immediately; the first request after release is at 8000_0000.
